// File: rtl/ats21_alarm_event_queue.sv
// Alarm event queue: detects new alarm assertions, holds them as pending, and
// feeds their IDs lowest-index-first into a first-word-fall-through FIFO.
module ats21_alarm_event_queue #(
  parameter int NUM_ALARMS = 24,
  parameter int ID_W       = 5,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_ALARMS-1:0] alarm_in,
  output logic                  evt_valid,
  output logic [ID_W-1:0]       evt_id,
  input  logic                  evt_ready,
  output logic [NUM_ALARMS-1:0] pending,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  clr_overflow
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = 9;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  logic [NUM_ALARMS-1:0] r_prev;
  logic [NUM_ALARMS-1:0] r_pending;
  logic [ID_W-1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic [7:0]            r_drop_count;

  logic [NUM_ALARMS-1:0] w_rise;
  logic [NUM_ALARMS-1:0] w_push_mask;
  logic [NUM_ALARMS-1:0] w_drop_vec;
  logic [ID_W-1:0]       w_head_idx;
  logic [DROP_W-1:0]     w_drop_n;
  logic [DROP_W-1:0]     w_drop_base;
  logic [DROP_W-1:0]     w_drop_sum;
  logic [7:0]            w_drop_next;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop_any;

  assign w_rise     = alarm_in & ~r_prev;
  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & evt_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_push     = (r_pending != '0) && ((r_count < FULL_C) || w_pop);
  assign w_drop_vec = w_rise & r_pending & ~w_push_mask;
  assign w_drop_any = (w_drop_vec != '0);

  // Lowest-index pending bit wins the push slot.
  always_comb begin
    w_head_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      w_head_idx = r_pending[i] ? ID_W'(i) : w_head_idx;
    end
  end

  // One-hot mask of the bit being pushed this cycle.
  always_comb begin
    w_push_mask = '0;
    if (w_push) begin
      w_push_mask[w_head_idx] = 1'b1;
    end else begin
      w_push_mask = '0;
    end
  end

  // Drop accounting: clear applies first so a same-cycle drop still lands.
  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      w_drop_n = w_drop_n + DROP_W'(w_drop_vec[i]);
    end
    w_drop_base = clr_overflow ? '0 : {1'b0, r_drop_count};
    w_drop_sum  = w_drop_base + w_drop_n;
    w_drop_next = (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
  end

  // Edge detect, pending set, FIFO storage/pointers and overflow state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev       <= '0;
      r_pending    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_prev       <= alarm_in;
      r_pending    <= (r_pending & ~w_push_mask) | w_rise;
      r_drop_count <= w_drop_next;
      if (w_drop_any) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_head_idx;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign evt_valid  = w_valid;
  assign evt_id     = w_valid ? r_mem[r_rd_ptr] : '0;
  assign pending    = r_pending;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_ats21_alarm_event_queue.sv
// Directed bench for ats21_alarm_event_queue: hand-computed expectations
// checked with immediate assertions after each clock edge.
module tb_ats21_alarm_event_queue;

  logic        clk;
  logic        reset;
  logic [23:0] alarm_in;
  logic        evt_valid;
  logic [4:0]  evt_id;
  logic        evt_ready;
  logic [23:0] pending;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clr_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ats21_alarm_event_queue #(.NUM_ALARMS(24), .ID_W(5), .DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .alarm_in     (alarm_in),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ready    (evt_ready),
    .pending      (pending),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b0;
    alarm_in     = 24'h0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    tick;
    tick;
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_id", 32'(evt_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b1;
    tick;

    // Single 2-cycle pulse on alarm 5
    alarm_in = 24'h000020;
    tick;
    check("a_pend_e0", 32'(pending), 32'h20);
    check("a_valid_e0", 32'(evt_valid), 32'd0);
    tick;
    alarm_in = 24'h0;
    check("a_valid_e1", 32'(evt_valid), 32'd1);
    check("a_id_e1", 32'(evt_id), 32'd5);
    check("a_pend_e1", 32'(pending), 32'd0);
    tick;
    check("a_still_one", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    check("a_one_entry", 32'(evt_valid), 32'd0);
    check("a_drop", 32'(drop_count), 32'd0);

    // Simultaneous rises on 0, 7, 23 with the consumer always ready
    evt_ready = 1'b1;
    alarm_in  = 24'h800081;
    tick;
    check("b_pend_e0", 32'(pending), 32'h800081);
    tick;
    alarm_in = 24'h0;
    check("b_id0", 32'(evt_id), 32'd0);
    check("b_valid0", 32'(evt_valid), 32'd1);
    tick;
    check("b_id7", 32'(evt_id), 32'd7);
    tick;
    check("b_id23", 32'(evt_id), 32'd23);
    check("b_pend_clear", 32'(pending), 32'd0);
    tick;
    check("b_empty", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Alarms 0..9 in successive pulses: 0..7 fill the FIFO, 8 and 9 wait
    for (int k = 0; k < 10; k++) begin
      alarm_in = 24'h1 << k;
      tick;
      tick;
    end
    alarm_in = 24'h0;
    tick;
    check("c_pend_8_9", 32'(pending), 32'h300);
    check("c_head0", 32'(evt_id), 32'd0);
    alarm_in = 24'h000100;
    tick;
    check("c_drop1", 32'(drop_count), 32'd1);
    check("c_ovf1", 32'(overflow), 32'd1);
    alarm_in = 24'h0;
    tick;
    check("c_pend_keep", 32'(pending), 32'h300);
    evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("c_drain%0d", k), 32'(evt_id), 32'(k));
      tick;
    end
    check("c_drained", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Full FIFO: push of pending[2] alongside a pop keeps 8 entries, no drop
    alarm_in = 24'h03FC00;
    tick;
    tick;
    alarm_in = 24'h0;
    repeat (7) tick;
    check("d_full_pend", 32'(pending), 32'd0);
    alarm_in = 24'h000004;
    tick;
    tick;
    alarm_in = 24'h0;
    check("d_pend2", 32'(pending), 32'h4);
    check("d_head10", 32'(evt_id), 32'd10);
    evt_ready = 1'b1;
    tick;
    evt_ready = 1'b0;
    check("d_pend_pushed", 32'(pending), 32'd0);
    check("d_no_drop", 32'(drop_count), 32'd1);
    check("d_head11", 32'(evt_id), 32'd11);
    evt_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("d_drain%0d", j), 32'(evt_id), (j < 7) ? 32'(11 + j) : 32'd2);
      tick;
    end
    check("d_drained", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Clear racing a drop, clear alone, then saturation
    alarm_in = 24'h0000FF;
    tick;
    tick;
    alarm_in = 24'h0;
    repeat (7) tick;
    check("e_full_head", 32'(evt_id), 32'd0);
    alarm_in = 24'h100000;
    tick;
    tick;
    alarm_in = 24'h0;
    tick;
    check("e_pend20", 32'(pending), 32'h100000);
    alarm_in     = 24'h100000;
    clr_overflow = 1'b1;
    tick;
    clr_overflow = 1'b0;
    alarm_in     = 24'h0;
    check("e_clr_drop_ovf", 32'(overflow), 32'd1);
    check("e_clr_drop_cnt", 32'(drop_count), 32'd1);
    clr_overflow = 1'b1;
    tick;
    clr_overflow = 1'b0;
    check("e_clr_ovf", 32'(overflow), 32'd0);
    check("e_clr_cnt", 32'(drop_count), 32'd0);
    alarm_in = 24'hFFFFFF;
    tick;
    alarm_in = 24'h0;
    check("e_first_all", 32'(drop_count), 32'd1);
    check("e_pend_all", 32'(pending), 32'hFFFFFF);
    tick;
    for (int t = 0; t < 10; t++) begin
      alarm_in = 24'hFFFFFF;
      tick;
      alarm_in = 24'h0;
      tick;
    end
    check("e_cnt241", 32'(drop_count), 32'd241);
    for (int t = 0; t < 3; t++) begin
      alarm_in = 24'hFFFFFF;
      tick;
      alarm_in = 24'h0;
      tick;
    end
    check("e_sat255", 32'(drop_count), 32'd255);
    check("e_ovf_set", 32'(overflow), 32'd1);

    // Asynchronous reset with 4 entries queued, alarm 1 held through release
    reset = 1'b0;
    tick;
    reset = 1'b1;
    check("f_clean", 32'(evt_valid), 32'd0);
    alarm_in = 24'h00003F;
    tick;
    tick;
    alarm_in = 24'h0;
    tick;
    tick;
    tick;
    check("f_head0", 32'(evt_id), 32'd0);
    check("f_pend45", 32'(pending), 32'h30);
    #2;
    reset = 1'b0;
    #1;
    check("f_async_valid", 32'(evt_valid), 32'd0);
    check("f_async_pend", 32'(pending), 32'd0);
    check("f_async_id", 32'(evt_id), 32'd0);
    alarm_in = 24'h000002;
    tick;
    tick;
    reset = 1'b1;
    tick;
    check("f_rel_pend", 32'(pending), 32'h2);
    check("f_rel_valid0", 32'(evt_valid), 32'd0);
    tick;
    check("f_rel_valid1", 32'(evt_valid), 32'd1);
    check("f_rel_id1", 32'(evt_id), 32'd1);
    check("f_rel_ovf", 32'(overflow), 32'd0);
    check("f_rel_drop", 32'(drop_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ats21_alarm_event_queue.md
# ats21_alarm_event_queue

Downstream consumer of the ATS21 alarm outputs. Samples the 24-bit alarm/timer `finished` vector, detects each new assertion, and converts it into a 5-bit alarm ID. IDs are queued in a small FIFO that a host or interrupt controller drains with a valid/ready handshake. Lost events are counted so software can detect missed alarms.

## Interface
- `NUM_ALARMS`, default 24: width of the alarm vector.
- `ID_W`, default 5: width of an alarm ID; must satisfy 2^ID_W ≥ NUM_ALARMS.
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 2.
- `clk` input, 1 bit: single clock, rising edge. Same clock that drives the ATS21.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `alarm_in` input, NUM_ALARMS bits: ATS21 `data` output. A bit is high for 2 cycles per firing.
- `evt_valid` output, 1 bit: FIFO head holds a valid ID.
- `evt_id` output, ID_W bits: alarm ID at the FIFO head (first-word-fall-through).
- `evt_ready` input, 1 bit: consumer accepts the head this cycle.
- `pending` output, NUM_ALARMS bits: detected events not yet written to the FIFO.
- `overflow` output, 1 bit: sticky flag, set when any event is dropped.
- `drop_count` output, 8 bits: saturating count of dropped events.
- `clr_overflow` input, 1 bit: synchronous clear of `overflow` and `drop_count`.

## Operation
- `prev` register holds the previous cycle's `alarm_in`.
- `rise = alarm_in & ~prev`. The 2-cycle ATS21 pulse therefore yields exactly one event.
- Pending update each edge: `pending_next = (pending & ~push_mask) | rise`.
- Push selection:
  - A push occurs when `pending != 0` and the FIFO can accept an entry: `count < DEPTH`, or `count == DEPTH` with a pop in the same cycle.
  - The pushed ID is the lowest-index set bit of the registered `pending`.
  - `push_mask` is the one-hot bit of that ID.
  - One push per cycle at most.
- Drop: a `rise` bit whose `pending` bit is already set and is not in `push_mask` that cycle.
  - Each such bit increments `drop_count` by one, summed across bits and saturating at 255.
  - Any drop sets `overflow`.
- A `rise` on the same bit as `push_mask` is not a drop. The ID is pushed and the bit stays pending.
- FIFO: circular buffer with `wr_ptr`/`rd_ptr` of log2(DEPTH) bits that wrap, plus a `count` register of log2(DEPTH)+1 bits.
  - Pop occurs when `evt_valid && evt_ready`.
  - `evt_valid = (count != 0)`. `evt_id = mem[rd_ptr]`.
  - Simultaneous push and pop leaves `count` unchanged. This is legal when full and when holding exactly one entry.
  - `evt_ready` while empty has no effect.
- `clr_overflow` clears `overflow` and `drop_count`. If a drop occurs in the same cycle, the drop wins: `overflow=1` and `drop_count` = number of bits dropped that cycle.
- The FIFO stores IDs only. Multiple firings of one alarm while its ID is queued (but not pending) each produce a separate entry.

## Timing
- Reset (async assert, sync release):
  - `prev`, `pending`, `count`, `wr_ptr`, `rd_ptr`, `overflow`, `drop_count` are all 0.
  - Outputs: `evt_valid=0`, `evt_id=0`, `pending=0`, `overflow=0`, `drop_count=0`.
- A bit that is high at reset release counts as a rise on the first edge.
- Reset mid-operation discards all queued and pending events immediately. No partial pop is visible.
- Latency, with `alarm_in[k]` rising before edge E0 and the FIFO empty:
  - `pending[k]=1` after E0.
  - ID k written at E1; `evt_valid=1` and `evt_id=k` after E1.
  - Two edges from input to visible event.
- Priority: simultaneous rises on bits 3 and 17 are queued as 3 at E1, then 17 at E2.
- The pop takes effect at the edge where `evt_valid && evt_ready`. The next head is visible after that edge.
- Steady-state throughput: one event per cycle.

## Test plan
- Reset, then pulse `alarm_in[5]` for 2 cycles with `evt_ready=0` → `evt_valid=1`, `evt_id=5` two edges after the rise. Exactly one entry; `drop_count=0`.
- Rise bits 0, 7 and 23 in the same cycle with `evt_ready=1` → IDs 0, 7, 23 appear on consecutive cycles and `pending` returns to 0.
- `DEPTH=8`, `evt_ready=0`, fire alarms 0–9 in successive pulses → FIFO holds 0–7 and `pending` holds bits 8 and 9. A second firing of alarm 8 → `drop_count=1`, `overflow=1`. Then `evt_ready=1` → drains 0–7, 8, 9 in order.
- Hold the FIFO full. On the edge where one entry pops, `pending[2]` is pushed in the same cycle → `count` stays 8 and no drop occurs.
- Assert `clr_overflow` together with a new drop → `overflow=1`, `drop_count=1`. Assert `clr_overflow` alone → both 0. Force 300 drops → `drop_count` saturates at 255.
- Assert `reset` low asynchronously mid-cycle with 4 entries queued → `evt_valid` and `pending` go to 0 immediately, with no clock edge. Hold `alarm_in[1]` high through the release → ID 1 is queued two edges later.
